axi_write_slave_burst: RTL and testbench
========================================

# axi_write_slave_burst

Parametrised AXI3 write-channel slave terminating AW/W/B traffic from the interconnect and presenting one address/data/strobe beat at a time to a local memory-mapped device over a valid/ready port. It supports FIXED, INCR and WRAP bursts up to 16 beats, configurable data/address/ID widths, per-beat device back-pressure, and checked write responses (OKAY/SLVERR).

## Interface
- DATA_W, 32, data bus width in bits (32, 64 or 128)
- ADDR_W, 32, address width
- ID_W, 4, transaction ID width
- ACLK  in  1  clock, all logic rising-edge
- ARESETn  in  1  synchronous, active-low reset
- AWID  in  ID_W  write address ID
- AWADDR  in  ADDR_W  burst start address
- AWLEN  in  4  beats minus one
- AWSIZE  in  3  bytes per beat = 2**AWSIZE
- AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- AWVALID / AWREADY  in / out  1  address handshake
- WID  in  ID_W  write data ID
- WDATA  in  DATA_W  write data
- WSTRB  in  DATA_W/8  byte strobes
- WLAST  in  1  last beat marker
- WVALID / WREADY  in / out  1  data handshake
- BID  out  ID_W  response ID
- BRESP  out  2  00 OKAY, 10 SLVERR
- BVALID / BREADY  out / in  1  response handshake
- dev_addr  out  ADDR_W  current beat address
- dev_data  out  DATA_W  current beat data (WDATA passthrough)
- dev_strb  out  DATA_W/8  current beat strobes (zeroed on error beats)
- dev_valid  out  1  beat presented to device
- dev_ready  in  1  device accepts beat this cycle

## Operation
- FSM states IDLE, DATA, RESP. Reset: state IDLE; AWREADY=1, WREADY=0, BVALID=0, BRESP=00, BID=0, dev_valid=0, dev_addr=0, beat counter=0, error flag=0.
- IDLE: AWREADY=1. On AWVALID: register AWID, AWADDR, AWLEN, AWSIZE, AWBURST; load dev_addr=AWADDR, counter=0, error flag = (2**AWSIZE > DATA_W/8) or AWBURST==11 or (WRAP and AWLEN not in {1,3,7,15}); go DATA.
- DATA: AWREADY=0. dev_valid=WVALID; WREADY=dev_ready. Beat completes when WVALID&dev_ready. dev_strb=WSTRB unless error flag set or WID != registered ID (then 0, error flag set).
- Per completed beat: counter+1; next address — FIXED: unchanged; INCR or reserved: addr + 2**AWSIZE (ADDR_W wrap-around, no 4 KB check); WRAP: len_bytes=(AWLEN+1)<<AWSIZE, next = (addr & ~(len_bytes-1)) | ((addr + 2**AWSIZE) & (len_bytes-1)).
- Burst ends on the first completed beat with WLAST=1 or counter==AWLEN. WLAST and counter disagreeing (early or missing WLAST) sets SLVERR. Go RESP.
- RESP: BVALID=1, BID=registered ID, BRESP=10 if error flag else 00; held stable until BREADY, then IDLE. WREADY=0, dev_valid=0.

## Timing
- AW accept to first possible W beat: 1 cycle (DATA entered next edge).
- W beat latency: zero — WREADY is combinational from dev_ready; device sees beat in the handshake cycle.
- Last beat to BVALID: 1 cycle. BVALID&BREADY to AWREADY: 1 cycle. Minimum single-beat transaction: 3 cycles.
- No W accepted in IDLE (write-data-before-address not supported; WVALID held by master).
- dev_valid never asserted without WVALID; WVALID may not depend on WREADY (AXI rule, no deadlock).
- Reset asserted mid-burst: next edge returns to IDLE with reset values; partial burst abandoned, no B response.
- BREADY high on BVALID's first cycle: single-cycle response.

## Structure
- Package axi_wr_pkg: burst encodings (FIXED/INCR/WRAP), response codes (OKAY/SLVERR), FSM state enumeration.
- Sub-module axi_burst_addr_gen: combinational next-address from addr, AWSIZE, AWLEN, AWBURST; reused by the planned read slave.

## Test plan
- INCR, AWADDR=0x100, AWLEN=3, AWSIZE=2, dev_ready=1 -> dev_addr 0x100,0x104,0x108,0x10C; BRESP=00, BID=AWID.
- WRAP, AWADDR=0x38, AWLEN=3, AWSIZE=2 -> dev_addr 0x38,0x3C,0x30,0x34; BRESP=00.
- FIXED, AWADDR=0x200, AWLEN=2, dev_ready toggling 1/0 -> three beats all at 0x200, each WREADY only when dev_ready=1.
- AWLEN=3 with WLAST on beat 2 -> burst ends after beat 2, BRESP=10; AWSIZE=3 on DATA_W=32 -> dev_strb=0 every beat, BRESP=10.
- BREADY low 5 cycles -> BVALID/BID/BRESP stable, AWREADY=0 until handshake.
- ARESETn low during beat 2 of 4 -> all outputs at reset values next cycle, new burst completes normally.

Source files
------------

// File: rtl/axi_write_slave_burst_pkg.sv
// Shared AXI3 write-slave types: burst encodings, response codes, FSM states,
// and the WRAP burst-length legality check.
package axi_wr_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_RESP
    } state_e;

    function automatic logic wrap_len_ok(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

endpackage

// File: rtl/axi_write_slave_burst_if.sv
// AXI3 write channels (AW/W/B) plus the one-beat-at-a-time local device port.
interface axi_write_slave_burst_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]     AWID;
    logic [ADDR_W-1:0]   AWADDR;
    logic [3:0]          AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic                AWVALID;
    logic                AWREADY;
    logic [ID_W-1:0]     WID;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;
    logic [ID_W-1:0]     BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;
    logic [ADDR_W-1:0]   dev_addr;
    logic [DATA_W-1:0]   dev_data;
    logic [DATA_W/8-1:0] dev_strb;
    logic                dev_valid;
    logic                dev_ready;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WID, WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        output dev_addr, dev_data, dev_strb, dev_valid,
        input  dev_ready
    );

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WID, WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        input  dev_addr, dev_data, dev_strb, dev_valid,
        output dev_ready
    );

endinterface

// File: rtl/axi_write_slave_burst_addr_gen.sv
// Combinational AXI burst next-beat address; shared with the read slave.
module axi_burst_addr_gen
    import axi_wr_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [3:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr
);

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] wrap_mask;

    always_comb begin
        step      = ADDR_W'(1) << size;
        incr_addr = addr + step;
        // Window is (len+1) beats; the mask keeps the in-window offset only.
        wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        case (burst_e'(burst))
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_write_slave_burst.sv
// AXI3 write slave: accepts one AW burst, streams W beats to a local device
// with per-beat back-pressure, then returns a checked B response.
module axi_write_slave_burst
    import axi_wr_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
) (
    input logic                     ACLK,
    input logic                     ARESETn,
    axi_write_slave_burst_if.slave  bus
);

    localparam int unsigned STRB_W = DATA_W / 8;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        len_q, len_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        burst_q, burst_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] next_addr;
    logic              wid_bad;
    logic              at_len;

    axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        wid_bad = 1'b0;
        at_len  = 1'b0;

        bus.AWREADY   = 1'b0;
        bus.WREADY    = 1'b0;
        bus.BVALID    = 1'b0;
        bus.BID       = '0;
        bus.BRESP     = RESP_OKAY;
        bus.dev_valid = 1'b0;
        bus.dev_strb  = '0;
        bus.dev_addr  = addr_q;
        bus.dev_data  = bus.WDATA;

        case (state_q)
            ST_IDLE: begin
                bus.AWREADY = 1'b1;
                if (bus.AWVALID) begin
                    id_d    = bus.AWID;
                    addr_d  = bus.AWADDR;
                    len_d   = bus.AWLEN;
                    size_d  = bus.AWSIZE;
                    burst_d = bus.AWBURST;
                    cnt_d   = '0;
                    err_d   = ((32'd1 << bus.AWSIZE) > STRB_W)
                           || (burst_e'(bus.AWBURST) == BURST_RSVD)
                           || ((burst_e'(bus.AWBURST) == BURST_WRAP) && !wrap_len_ok(bus.AWLEN));
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                bus.dev_valid = bus.WVALID;
                bus.WREADY    = bus.dev_ready;
                wid_bad       = (bus.WID != id_q);
                bus.dev_strb  = (err_q || wid_bad) ? '0 : bus.WSTRB;
                at_len        = (cnt_q == len_q);
                if (bus.WVALID && bus.dev_ready) begin
                    cnt_d  = cnt_q + 4'd1;
                    addr_d = next_addr;
                    // WLAST must coincide with the AWLEN-th beat; either ends the burst.
                    if (wid_bad || (bus.WLAST != at_len))
                        err_d = 1'b1;
                    if (bus.WLAST || at_len)
                        state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                bus.BVALID = 1'b1;
                bus.BID    = id_q;
                bus.BRESP  = err_q ? RESP_SLVERR : RESP_OKAY;
                if (bus.BREADY)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_write_slave_burst.sv
// Directed bench for axi_write_slave_burst: burst table plus hand-written
// back-pressure, response-stall and mid-burst reset sequences.
module tb_axi_write_slave_burst;

    localparam int NV = 11;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          wlast_at;
        int          bad_wid_at;
        int          nbeats;
        int          zero_from;
        logic [1:0]  resp;
    } vec_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    vec_t        v  [NV];
    logic [31:0] ea [NV][8];

    axi_write_slave_burst_if #(.DATA_W(32), .ADDR_W(32), .ID_W(4)) bus ();

    axi_write_slave_burst #(.DATA_W(32), .ADDR_W(32), .ID_W(4)) dut (
        .ACLK    (clk),
        .ARESETn (rstn),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        @(negedge clk);
        bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len;
        bus.AWSIZE = size; bus.AWBURST = burst; bus.AWVALID = 1'b1;
        check("awready_idle", bus.AWREADY, 1);
        @(posedge clk); #1;
        bus.AWVALID = 1'b0;
    endtask

    task automatic run_vec(input int i);
        logic [3:0]  strb;
        logic [31:0] data;
        send_aw(v[i].id, v[i].addr, v[i].len, v[i].size, v[i].burst);
        bus.BREADY = 1'b1;
        for (int b = 0; b < v[i].nbeats; b++) begin
            strb = 4'(b) | 4'h8;
            data = 32'hA500_0000 | 32'(b);
            bus.WVALID = 1'b1; bus.dev_ready = 1'b1;
            bus.WID    = (b == v[i].bad_wid_at) ? (v[i].id ^ 4'h1) : v[i].id;
            bus.WDATA  = data; bus.WSTRB = strb;
            bus.WLAST  = (b == v[i].wlast_at);
            @(negedge clk);
            check("dev_valid", bus.dev_valid, 1);
            check("wready", bus.WREADY, 1);
            check("dev_addr", bus.dev_addr, ea[i][b]);
            check("dev_data", bus.dev_data, data);
            check("dev_strb", bus.dev_strb, (b >= v[i].zero_from) ? 4'h0 : strb);
            check("bvalid_data", bus.BVALID, 0);
            @(posedge clk); #1;
        end
        bus.WVALID = 1'b0; bus.WLAST = 1'b0;
        @(negedge clk);
        check("bvalid", bus.BVALID, 1);
        check("bid", bus.BID, v[i].id);
        check("bresp", bus.BRESP, v[i].resp);
        check("wready_resp", bus.WREADY, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bvalid_done", bus.BVALID, 0);
        check("awready_back", bus.AWREADY, 1);
    endtask

    initial begin
        bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0;
        bus.AWBURST = '0; bus.AWVALID = 1'b0;
        bus.WID = '0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0;
        bus.WVALID = 1'b1; bus.BREADY = 1'b0; bus.dev_ready = 1'b1;

        v[0]  = '{4'h5, 32'h100,      4'd3, 3'd2, 2'b01, 3,  99, 4, 99, 2'b00};
        ea[0] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h0, 32'h0, 32'h0, 32'h0};
        v[1]  = '{4'h3, 32'h38,       4'd3, 3'd2, 2'b10, 3,  99, 4, 99, 2'b00};
        ea[1] = '{32'h38, 32'h3C, 32'h30, 32'h34, 32'h0, 32'h0, 32'h0, 32'h0};
        v[2]  = '{4'h1, 32'h0,        4'd3, 3'd2, 2'b01, 1,  99, 2, 99, 2'b10};
        ea[2] = '{32'h0, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        v[3]  = '{4'h7, 32'h40,       4'd1, 3'd3, 2'b01, 1,  99, 2, 0,  2'b10};
        ea[3] = '{32'h40, 32'h48, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        v[4]  = '{4'h2, 32'h20,       4'd2, 3'd2, 2'b10, 2,  99, 3, 0,  2'b10};
        ea[4] = '{32'h20, 32'h20, 32'h20, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        v[5]  = '{4'h4, 32'h10,       4'd1, 3'd2, 2'b11, 1,  99, 2, 0,  2'b10};
        ea[5] = '{32'h10, 32'h14, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        v[6]  = '{4'h6, 32'h300,      4'd1, 3'd2, 2'b01, 99, 99, 2, 99, 2'b10};
        ea[6] = '{32'h300, 32'h304, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        v[7]  = '{4'h8, 32'hFFFFFFFC, 4'd1, 3'd2, 2'b01, 1,  99, 2, 99, 2'b00};
        ea[7] = '{32'hFFFFFFFC, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        v[8]  = '{4'h9, 32'h44,       4'd1, 3'd2, 2'b10, 1,  99, 2, 99, 2'b00};
        ea[8] = '{32'h44, 32'h40, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        v[9]  = '{4'hA, 32'h105,      4'd7, 3'd0, 2'b10, 7,  99, 8, 99, 2'b00};
        ea[9] = '{32'h105, 32'h106, 32'h107, 32'h100, 32'h101, 32'h102, 32'h103, 32'h104};
        v[10] = '{4'hB, 32'h500,      4'd1, 3'd2, 2'b01, 1,  1,  2, 1,  2'b10};
        ea[10] = '{32'h500, 32'h504, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

        // Reset state; WVALID/dev_ready held high to show no W is taken in IDLE.
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("rst_awready", bus.AWREADY, 1);
        check("rst_wready", bus.WREADY, 0);
        check("rst_dev_valid", bus.dev_valid, 0);
        check("rst_bvalid", bus.BVALID, 0);
        check("rst_bresp", bus.BRESP, 0);
        check("rst_bid", bus.BID, 0);
        check("rst_dev_addr", bus.dev_addr, 0);
        @(posedge clk); #1;
        bus.WVALID = 1'b0;

        for (int i = 0; i < NV; i++)
            run_vec(i);

        // FIXED burst under alternating device back-pressure.
        begin
            int nb = 0;
            send_aw(4'h6, 32'h200, 4'd2, 3'd2, 2'b00);
            bus.BREADY = 1'b1;
            for (int k = 0; k < 5; k++) begin
                logic rdy;
                rdy = (k % 2 == 0);
                bus.WVALID = 1'b1; bus.WID = 4'h6; bus.WSTRB = 4'hF;
                bus.WDATA = 32'(k); bus.WLAST = (nb == 2); bus.dev_ready = rdy;
                @(negedge clk);
                check("fix_wready", bus.WREADY, rdy);
                check("fix_dev_valid", bus.dev_valid, 1);
                check("fix_dev_addr", bus.dev_addr, 32'h200);
                @(posedge clk); #1;
                if (rdy) nb++;
            end
            bus.WVALID = 1'b0; bus.WLAST = 1'b0; bus.dev_ready = 1'b1;
            @(negedge clk);
            check("fix_bvalid", bus.BVALID, 1);
            check("fix_bresp", bus.BRESP, 2'b00);
            check("fix_bid", bus.BID, 4'h6);
            @(posedge clk); #1;
        end

        // Response held while BREADY is low; oversize beat yields SLVERR.
        send_aw(4'h9, 32'h80, 4'd0, 3'd3, 2'b01);
        bus.BREADY = 1'b0;
        bus.WVALID = 1'b1; bus.WID = 4'h9; bus.WSTRB = 4'hF; bus.WLAST = 1'b1;
        @(negedge clk);
        check("stall_dev_strb", bus.dev_strb, 4'h0);
        @(posedge clk); #1;
        bus.WVALID = 1'b0; bus.WLAST = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_bvalid", bus.BVALID, 1);
            check("stall_bid", bus.BID, 4'h9);
            check("stall_bresp", bus.BRESP, 2'b10);
            check("stall_awready", bus.AWREADY, 0);
            @(posedge clk); #1;
        end
        bus.BREADY = 1'b1;
        @(negedge clk);
        check("stall_bvalid_hs", bus.BVALID, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("stall_bvalid_done", bus.BVALID, 0);
        check("stall_awready_done", bus.AWREADY, 1);

        // Reset during beat 2 of a 4-beat burst.
        send_aw(4'h4, 32'h600, 4'd3, 3'd2, 2'b01);
        bus.WVALID = 1'b1; bus.WID = 4'h4; bus.WSTRB = 4'hF; bus.WLAST = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b0;
        @(negedge clk);
        check("mid_dev_addr_beat2", bus.dev_addr, 32'h604);
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_rst_awready", bus.AWREADY, 1);
        check("mid_rst_wready", bus.WREADY, 0);
        check("mid_rst_dev_valid", bus.dev_valid, 0);
        check("mid_rst_dev_addr", bus.dev_addr, 0);
        check("mid_rst_bvalid", bus.BVALID, 0);
        check("mid_rst_bid", bus.BID, 0);
        @(posedge clk); #1;
        rstn = 1'b1; bus.WVALID = 1'b0;
        run_vec(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
